id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus operand issue for the EX stage. Captures one decoded
//  instruction per cycle and resolves EX/MEM and MEM/WB forwarding. Drives the ALU a/b/control
//  inputs; the ALU registers its result on the next clk edge.
//  Detects load-use hazards, inserts one bubble for each, and honours downstream stall and flush.
// PARAMETERS
//  WIDTH  32  datapath width (pc, register values, immediate, ALU operands)
// PORTS
//  clk              in   1      system clock, all state on posedge
//  rst              in   1      synchronous reset, active-high
//  in_valid         in   1      decode stage presents an instruction
//  in_ready         out  1      stage accepts in_* this cycle (combinational)
//  in_pc            in   WIDTH  instruction pc
//  in_rs1_val       in   WIDTH  register-file read of rs1
//  in_rs2_val       in   WIDTH  register-file read of rs2
//  in_imm           in   WIDTH  sign-extended immediate
//  in_rs1_addr      in   5      rs1 index
//  in_rs2_addr      in   5      rs2 index
//  in_rd_addr       in   5      destination index
//  in_alu_ctrl      in   4      ALU control code (`ALU_* from parameters.vh)
//  in_use_imm       in   1      1: alu_b = imm, 0: alu_b = forwarded rs2
//  in_use_pc        in   1      1: alu_a = pc,  0: alu_a = forwarded rs1
//  in_reg_write     in   1      instruction writes rd
//  in_mem_read      in   1      instruction is a load
//  stall            in   1      downstream hold: freeze all state
//  flush            in   1      kill the instruction held in this stage (branch redirect)
//  exmem_rd         in   5      EX/MEM destination index
//  exmem_reg_write  in   1      EX/MEM will write exmem_rd
//  exmem_value      in   WIDTH  EX/MEM result
//  memwb_rd         in   5      MEM/WB destination index
//  memwb_reg_write  in   1      MEM/WB will write memwb_rd
//  memwb_value      in   WIDTH  MEM/WB writeback value
//  out_valid        out  1      held instruction is live
//  alu_a            out  WIDTH  ALU operand a (combinational from held state and forwarding)
//  alu_b            out  WIDTH  ALU operand b
//  alu_control      out  4      ALU control (registered)
//  store_data       out  WIDTH  forwarded rs2 for stores
//  out_rd           out  5      held rd
//  out_reg_write    out  1      held reg_write, gated by out_valid
//  out_mem_read     out  1      held mem_read, gated by out_valid
// BEHAVIOUR
//  - Reset: out_valid=0, all held fields 0, alu_control=`ALU_ADD, so alu_a=alu_b=0 and
//    out_reg_write=out_mem_read=0.
//  - Load-use hazard: hz = in_valid & out_valid & out_mem_read & out_rd!=0 &
//    (out_rd==in_rs1_addr | out_rd==in_rs2_addr).
//  - in_ready = ~stall & ~hz, or 1 whenever flush=1 (the input is accepted and dropped).
//  - Per-edge priority:
//    rst > flush > stall > hz > normal.
//    - flush: out_valid<=0 and the control fields clear; in_* is discarded.
//    - stall: all state holds.
//    - hz: bubble; out_valid<=0 and the instruction stays on in_* until the next cycle.
//    - normal: capture in_*; out_valid<=in_valid.
//  - On a bubble or an invalid capture, alu_control<=`ALU_ADD and the operand registers <=0.
//  - Forwarding applies to held rs1 and rs2 independently and is combinational every cycle,
//    so it tracks producers while stalled. Index 0 is never forwarded.
//    1. If exmem_reg_write & exmem_rd==rs, use exmem_value.
//    2. Otherwise, if memwb_reg_write & memwb_rd==rs, use memwb_value.
//    3. Otherwise, use the held register value.
//  - alu_a = use_pc ? pc : fwd_rs1
//  - alu_b = use_imm ? imm : fwd_rs2
//  - store_data = fwd_rs2, always.
//  - Latency: in_* is captured at edge N; the operands are valid after edge N.
//    The ALU result registers at edge N+1.
//  - Back-to-back accept at one instruction per cycle when there is no stall or hazard.
//  - rst asserted mid-stream drops the held instruction on the next edge.
// CONFIGURATION
//  ID_EX_STATS_EN defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
//    - Both are saturating counters, cleared by rst.
//    - stall_cnt increments on every edge with stall=1 and flush=0.
//    - bubble_cnt increments on every edge where an hz bubble is inserted.
//  ID_EX_STATS_EN undefined: the counters and their ports are absent; all other behaviour
//    is identical.
// TESTING
//  1. Reset: rst=1 for 2 cycles, then inspect the stage.
//     -> out_valid=0, alu_a=0, alu_b=0, alu_control=`ALU_ADD, in_ready=1.
//  2. Immediate ADD: capture rs1_val=5, imm=7, use_imm=1, ctrl=`ALU_ADD.
//     -> Next cycle alu_a=5, alu_b=7, out_valid=1; ALU out=12 one edge later.
//  3. Forwarding priority: held rs1=3; exmem_rd=3 (value 0x10) and memwb_rd=3 (value 0x20),
//     both writing -> alu_a=0x10. Drop exmem_reg_write -> alu_a=0x20.
//     With rs1=0, both producers at rd=0 -> alu_a = the held value.
//  4. Load-use: lw x5 held, add x6,x5,x1 presented.
//     -> in_ready=0 for 1 cycle and out_valid=0 next cycle; add captured the cycle after.
//     -> bubble_cnt=1 if stats are enabled.
//  5. flush=1 and stall=1 in the same cycle with a valid instruction held.
//     -> out_valid=0 next cycle, in_ready=1 during the flush cycle.
//  6. stall held for 4 cycles mid-stream.
//     -> alu_control and out_rd unchanged and in_ready=0 throughout.
//     -> stall_cnt=4 if stats are enabled.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional build macro: ID_EX_STATS_EN adds saturating stall_cnt / bubble_cnt outputs.
module id_ex_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic [4:0]       in_rd_addr,
    input  logic [3:0]       in_alu_ctrl,
    input  logic             in_use_imm,
    input  logic             in_use_pc,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [WIDTH-1:0] exmem_value,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_reg_write,
    input  logic [WIDTH-1:0] memwb_value,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] store_data,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CTRL_W  = 4;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  pc;
        logic [WIDTH-1:0]  rs1_val;
        logic [WIDTH-1:0]  rs2_val;
        logic [WIDTH-1:0]  imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] alu_ctrl;
        logic              use_imm;
        logic              use_pc;
        logic              reg_write;
        logic              mem_read;
    } held_t;

    held_t q;
    held_t q_clr_c;
    held_t q_in_c;
    logic  hz_c;
    logic  [WIDTH-1:0] fwd_rs1_c;
    logic  [WIDTH-1:0] fwd_rs2_c;

    // Load-use hazard: a held load whose rd feeds the instruction being presented.
    assign hz_c = in_valid & q.valid & q.mem_read & (q.rd != '0) &
                  ((q.rd == in_rs1_addr) | (q.rd == in_rs2_addr));

    assign in_ready = flush | (~stall & ~hz_c);

    // Bubble value and incoming record.
    always_comb begin
        q_clr_c          = '0;
        q_clr_c.alu_ctrl = ALU_ADD;

        q_in_c           = '0;
        q_in_c.valid     = 1'b1;
        q_in_c.pc        = in_pc;
        q_in_c.rs1_val   = in_rs1_val;
        q_in_c.rs2_val   = in_rs2_val;
        q_in_c.imm       = in_imm;
        q_in_c.rs1_addr  = in_rs1_addr;
        q_in_c.rs2_addr  = in_rs2_addr;
        q_in_c.rd        = in_rd_addr;
        q_in_c.alu_ctrl  = in_alu_ctrl;
        q_in_c.use_imm   = in_use_imm;
        q_in_c.use_pc    = in_use_pc;
        q_in_c.reg_write = in_reg_write;
        q_in_c.mem_read  = in_mem_read;
    end

    // Pipeline register: rst > flush > stall > hazard bubble > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= q_clr_c;
        end else if (flush) begin
            q <= q_clr_c;
        end else if (stall) begin
            q <= q;
        end else if (hz_c || !in_valid) begin
            q <= q_clr_c;
        end else begin
            q <= q_in_c;
        end
    end

    // Forwarding; EX/MEM wins over MEM/WB, x0 is never forwarded.
    always_comb begin
        fwd_rs1_c = q.rs1_val;
        fwd_rs2_c = q.rs2_val;
        if (q.rs1_addr != '0) begin
            if (exmem_reg_write && (exmem_rd == q.rs1_addr)) begin
                fwd_rs1_c = exmem_value;
            end else if (memwb_reg_write && (memwb_rd == q.rs1_addr)) begin
                fwd_rs1_c = memwb_value;
            end
        end
        if (q.rs2_addr != '0) begin
            if (exmem_reg_write && (exmem_rd == q.rs2_addr)) begin
                fwd_rs2_c = exmem_value;
            end else if (memwb_reg_write && (memwb_rd == q.rs2_addr)) begin
                fwd_rs2_c = memwb_value;
            end
        end
    end

    assign alu_a         = q.use_pc  ? q.pc  : fwd_rs1_c;
    assign alu_b         = q.use_imm ? q.imm : fwd_rs2_c;
    assign store_data    = fwd_rs2_c;
    assign alu_control   = q.alu_ctrl;
    assign out_valid     = q.valid;
    assign out_rd        = q.rd;
    assign out_reg_write = q.reg_write & q.valid;
    assign out_mem_read  = q.mem_read & q.valid;

`ifdef ID_EX_STATS_EN
    // Saturating stall and bubble counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'(1);
            end
            if (!flush && !stall && hz_c && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
module tb_id_ex_stage;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_alu_ctrl;
    logic        in_use_imm, in_use_pc, in_reg_write, in_mem_read;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_value, memwb_value;
    logic        out_valid;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_control;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read;
`ifdef ID_EX_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    id_ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_ctrl(in_alu_ctrl), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_value(exmem_value),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_value(memwb_value),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .store_data(store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
`ifdef ID_EX_STATS_EN
        ,
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple downstream ALU result register (add/sub only).
    logic [31:0] alu_q;
    always_ff @(posedge clk) begin
        alu_q <= (alu_control == ALU_ADD) ? (alu_a + alu_b) : (alu_a - alu_b);
    end

    typedef struct {
        logic        rst, valid;
        logic [31:0] pc, r1v, r2v, imm;
        logic [4:0]  r1a, r2a, rd;
        logic [3:0]  ctrl;
        logic        ui, up, rw, mr, stall, flush;
        logic [4:0]  xrd, wrd;
        logic        xw, ww;
        logic [31:0] xv, wv;
        logic        chk_ready, e_ready, e_valid;
        logic [31:0] e_a, e_b, e_sd;
        logic [3:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic        e_rw, e_mr;
        logic [31:0] e_scnt, e_bcnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        v.chk_ready = 1'b1;
        v.e_ready   = 1'b1;
        v.e_ctrl    = ALU_ADD;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        rst = v.rst; in_valid = v.valid; in_pc = v.pc;
        in_rs1_val = v.r1v; in_rs2_val = v.r2v; in_imm = v.imm;
        in_rs1_addr = v.r1a; in_rs2_addr = v.r2a; in_rd_addr = v.rd;
        in_alu_ctrl = v.ctrl; in_use_imm = v.ui; in_use_pc = v.up;
        in_reg_write = v.rw; in_mem_read = v.mr; stall = v.stall; flush = v.flush;
        exmem_rd = v.xrd; exmem_reg_write = v.xw; exmem_value = v.xv;
        memwb_rd = v.wrd; memwb_reg_write = v.ww; memwb_value = v.wv;
        #1;
        if (v.chk_ready) chk("in_ready", row, 32'(in_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        chk("out_valid", row, 32'(out_valid), 32'(v.e_valid));
        chk("alu_a", row, alu_a, v.e_a);
        chk("alu_b", row, alu_b, v.e_b);
        chk("alu_control", row, 32'(alu_control), 32'(v.e_ctrl));
        chk("out_rd", row, 32'(out_rd), 32'(v.e_rd));
        chk("store_data", row, store_data, v.e_sd);
        chk("out_reg_write", row, 32'(out_reg_write), 32'(v.e_rw));
        chk("out_mem_read", row, 32'(out_mem_read), 32'(v.e_mr));
`ifdef ID_EX_STATS_EN
        chk("stall_cnt", row, stall_cnt, v.e_scnt);
        chk("bubble_cnt", row, bubble_cnt, v.e_bcnt);
`endif
    endtask

    vec_t tbl[$];
    vec_t v, r_add, r_ldu, r_stl;

    initial begin
        // reset, two cycles
        v = blank(); v.rst = 1; v.chk_ready = 0; tbl.push_back(v);
        v = blank(); v.rst = 1; tbl.push_back(v);
        // immediate add: 5 + imm 7
        v = blank(); v.valid = 1; v.pc = 32'h100; v.r1a = 1; v.r1v = 5; v.r2a = 4;
        v.r2v = 32'h33; v.imm = 7; v.ui = 1; v.rd = 2; v.rw = 1;
        v.e_valid = 1; v.e_a = 5; v.e_b = 7; v.e_rd = 2; v.e_sd = 32'h33; v.e_rw = 1;
        r_add = v; tbl.push_back(v);
        // forwarding priority: EX/MEM beats MEM/WB
        v = blank(); v.valid = 1; v.pc = 32'h104; v.r1a = 3; v.r1v = 1; v.r2v = 9;
        v.ctrl = ALU_SUB; v.rd = 7; v.rw = 1;
        v.xrd = 3; v.xw = 1; v.xv = 32'h10; v.wrd = 3; v.ww = 1; v.wv = 32'h20;
        v.e_valid = 1; v.e_a = 32'h10; v.e_b = 9; v.e_ctrl = ALU_SUB; v.e_rd = 7;
        v.e_sd = 9; v.e_rw = 1; tbl.push_back(v);
        // stalled, EX/MEM drops out: MEM/WB now forwards
        v.stall = 1; v.xw = 0; v.e_ready = 0; v.e_a = 32'h20; v.e_scnt = 1; tbl.push_back(v);
        // rs1=x0 with producers at rd=0: held value used
        v = blank(); v.valid = 1; v.r1v = 32'h44; v.r2v = 32'h55; v.rd = 8;
        v.xw = 1; v.xv = 32'h10; v.ww = 1; v.wv = 32'h20;
        v.e_valid = 1; v.e_a = 32'h44; v.e_b = 32'h55; v.e_sd = 32'h55; v.e_rd = 8;
        v.e_scnt = 1; tbl.push_back(v);
        // lw x5
        v = blank(); v.valid = 1; v.r1a = 2; v.r1v = 32'h1000; v.imm = 4; v.ui = 1;
        v.rd = 5; v.rw = 1; v.mr = 1;
        v.e_valid = 1; v.e_a = 32'h1000; v.e_b = 4; v.e_rd = 5; v.e_rw = 1; v.e_mr = 1;
        v.e_scnt = 1; tbl.push_back(v);
        // add x6,x5,x1 -> bubble
        v = blank(); v.valid = 1; v.r1a = 5; v.r2a = 1; v.r2v = 32'h11; v.rd = 6; v.rw = 1;
        v.e_ready = 0; v.e_scnt = 1; v.e_bcnt = 1; r_ldu = v; tbl.push_back(v);
        // add accepted next cycle, load value forwarded from MEM/WB
        v = r_ldu; v.wrd = 5; v.ww = 1; v.wv = 32'h77; v.e_ready = 1;
        v.e_valid = 1; v.e_a = 32'h77; v.e_b = 32'h11; v.e_rd = 6; v.e_sd = 32'h11;
        v.e_rw = 1; tbl.push_back(v);
        // flush and stall together
        v = blank(); v.valid = 1; v.rd = 9; v.r1a = 1; v.r1v = 32'hAA; v.ctrl = ALU_SUB;
        v.rw = 1; v.stall = 1; v.flush = 1; v.e_scnt = 1; v.e_bcnt = 1; tbl.push_back(v);
        // capture, then mid-stream reset drops it
        v = blank(); v.valid = 1; v.r1a = 1; v.r1v = 3; v.r2a = 2; v.r2v = 4;
        v.ctrl = ALU_SUB; v.rd = 10; v.rw = 1;
        v.e_valid = 1; v.e_a = 3; v.e_b = 4; v.e_ctrl = ALU_SUB; v.e_rd = 10; v.e_sd = 4;
        v.e_rw = 1; v.e_scnt = 1; v.e_bcnt = 1; tbl.push_back(v);
        r_stl = v; r_stl.e_scnt = 0; r_stl.e_bcnt = 0;
        v = blank(); v.rst = 1; v.valid = 1; v.rd = 10; v.r1a = 1; v.r1v = 3; v.rw = 1;
        tbl.push_back(v);
        tbl.push_back(r_stl);
        // four stall cycles with a different instruction presented
        for (int i = 1; i <= 4; i++) begin
            v = r_stl; v.stall = 1; v.rd = 11; v.ctrl = ALU_ADD; v.r1a = 5; v.r1v = 32'h99;
            v.e_ready = 0; v.e_scnt = 32'(i); tbl.push_back(v);
        end
        // invalid capture clears fields
        v = blank(); v.rd = 12; v.ctrl = ALU_SUB; v.r1v = 5; v.rw = 1; v.e_scnt = 4;
        tbl.push_back(v);
        // load to x0 then use of x0: no hazard
        v = blank(); v.valid = 1; v.r1a = 3; v.r1v = 32'h200; v.imm = 8; v.ui = 1;
        v.rw = 1; v.mr = 1;
        v.e_valid = 1; v.e_a = 32'h200; v.e_b = 8; v.e_rw = 1; v.e_mr = 1; v.e_scnt = 4;
        tbl.push_back(v);
        v = blank(); v.valid = 1; v.r1v = 1; v.r2v = 2; v.rd = 13; v.rw = 1;
        v.e_valid = 1; v.e_a = 1; v.e_b = 2; v.e_rd = 13; v.e_sd = 2; v.e_rw = 1;
        v.e_scnt = 4; tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // ALU result one edge after operands are valid
        v = r_add; v.e_scnt = 4;
        apply(v, 100);
        @(posedge clk);
        #1;
        chk("alu_result", 101, alu_q, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
